// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg : shared AES constants, S-box lookup and key-schedule FSM     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int NUM_ROUND_KEYS = 11;
  localparam int KEY_WIDTH      = 128;

  // rcon[0] sits in the low byte.
  localparam logic [9:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // S-box entry 0x00 occupies the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_TABLE[idx -: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_sub_word : AES SubWord, four parallel S-box lookups               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign o_word[8*gi +: 8] = sbox(i_word[8*gi +: 8]);
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_key_expander : AES-128 key schedule, one round key per cycle,     |
// | streamed into a round-key register file write port                   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [KEY_WIDTH-1:0]  key_in,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [KEY_WIDTH-1:0]  wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [3:0] c_LAST_RND = 4'(NUM_ROUND_KEYS - 1);

  state_e                r_state, w_state_nxt;
  logic [3:0]            r_rnd, w_rnd_nxt;
  logic [KEY_WIDTH-1:0]  r_key, w_key_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [KEY_WIDTH-1:0]  r_wr_data, w_wr_data_nxt;
  logic                  r_done, w_done_nxt;

  logic [31:0]           w_rot, w_sub, w_t;
  logic [7:0]            w_rcon;
  logic [31:0]           w_w0n, w_w1n, w_w2n, w_w3n;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_rot  = {r_key[23:0], r_key[31:24]};
  assign w_rcon = (r_rnd <= 4'd9) ? RCON[r_rnd] : 8'h00;

  aes_sub_word u_sub_word (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  assign w_t   = w_sub ^ {w_rcon, 24'h0};
  assign w_w0n = r_key[127:96] ^ w_t;
  assign w_w1n = r_key[95:64]  ^ w_w0n;
  assign w_w2n = r_key[63:32]  ^ w_w1n;
  assign w_w3n = r_key[31:0]   ^ w_w2n;

  assign w_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_rnd);

  // EXPAND spends one extra cycle after the last write (r_rnd == 11) so done
  // trails the final register-file write by a full cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_rnd_nxt     = r_rnd;
    w_key_nxt     = r_key;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_valid) begin
          w_key_nxt   = key_in;
          w_rnd_nxt   = 4'd0;
          w_state_nxt = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (r_rnd <= c_LAST_RND) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = w_addr;
          w_wr_data_nxt = r_key;
          w_key_nxt     = {w_w0n, w_w1n, w_w2n, w_w3n};
          w_rnd_nxt     = r_rnd + 4'd1;
        end else begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_rnd     <= 4'd0;
      r_key     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rnd     <= w_rnd_nxt;
      r_key     <= w_key_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && r_state == ST_EXPAND && r_rnd <= c_LAST_RND) begin
      assert ((BASE_ADDR + int'(r_rnd)) < (1 << ADDR_WIDTH))
        else $error("aes_key_expander: write address exceeds ADDR_WIDTH");
    end
  end

  assign start_ready = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes_key_expander : randomized bench against a word-level FIPS-197  |
// | key-schedule model; two instances (BASE_ADDR 0 and 5) in lockstep      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_aes_key_expander;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start_valid;
  logic [127:0] key_in;

  logic         ready0, wr_en0, busy0, done0;
  logic [3:0]   wr_addr0;
  logic [127:0] wr_data0;
  logic         ready5, wr_en5, busy5, done5;
  logic [3:0]   wr_addr5;
  logic [127:0] wr_data5;

  aes_key_expander #(.ADDR_WIDTH(4), .BASE_ADDR(0)) dut0 (
    .CLK(CLK), .RST(RST), .start_valid(start_valid), .start_ready(ready0),
    .key_in(key_in), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0)
  );

  aes_key_expander #(.ADDR_WIDTH(4), .BASE_ADDR(5)) dut5 (
    .CLK(CLK), .RST(RST), .start_valid(start_valid), .start_ready(ready5),
    .key_in(key_in), .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
    .busy(busy5), .done(done5)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt5  = 0;

  logic [7:0]   ref_sb [256];
  logic [127:0] sched  [11];
  logic [127:0] cap    [11];

  always @(negedge CLK) if (wr_en5) wr_cnt5++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_sched(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {ref_sb[temp[31:24]], ref_sb[temp[23:16]], ref_sb[temp[15:8]], ref_sb[temp[7:0]]}
               ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Accept edge is cycle 0; cycle c is sampled 1 time unit after the c-th edge.
  task automatic run_request(input logic [127:0] key, input bit hold,
                             input logic [127:0] other, input int rst_at);
    int  waited;
    bit  in_wr;
    waited = 0;
    while (!ready0 && waited < 20) begin
      @(posedge CLK); #1;
      waited++;
    end
    check("accept_ready", {ready0, ready5}, 2'b11);
    build_sched(key);
    wr_cnt5     = 0;
    start_valid = 1'b1;
    key_in      = key;
    @(posedge CLK); #1;
    if (hold) key_in = other;
    else begin
      start_valid = 1'b0;
      key_in      = rand_key();
    end
    for (int c = 1; c <= 13; c++) begin
      @(posedge CLK); #1;
      if (c == rst_at) begin
        check("pre_rst_wr_en", wr_en0, 1'b1);
        RST = 1'b1;
        #1;
        check("rst_wr_en", {wr_en0, wr_en5}, 2'b00);
        check("rst_busy", {busy0, busy5}, 2'b00);
        check("rst_ready", {ready0, ready5}, 2'b11);
        for (int j = 0; j < 3; j++) begin
          @(posedge CLK); #1;
          check("rst_no_done", {done0, done5, wr_en0, wr_en5}, 4'b0000);
        end
        RST = 1'b0;
        return;
      end
      in_wr = (c <= 11);
      check("wr_en", {wr_en0, wr_en5}, in_wr ? 2'b11 : 2'b00);
      if (in_wr) begin
        cap[c-1] = wr_data0;
        check("wr_addr_b0", 128'(wr_addr0), 128'(c - 1));
        check("wr_addr_b5", 128'(wr_addr5), 128'(c + 4));
        check("wr_data_b0", wr_data0, sched[c-1]);
        check("wr_data_b5", wr_data5, sched[c-1]);
      end
      check("done", {done0, done5}, (c == 12) ? 2'b11 : 2'b00);
      check("busy", {busy0, busy5}, (c <= 12) ? 2'b11 : 2'b00);
      check("ready", {ready0, ready5}, (c == 13) ? 2'b11 : 2'b00);
    end
    check("wr_count_b5", 128'(wr_cnt5), 128'd11);
  endtask

  initial begin
    logic [127:0] k1, k2;
    RST         = 1'b1;
    start_valid = 1'b0;
    key_in      = '0;
    init_sbox();
    #1;
    check("reset_wr_en",   {wr_en0, wr_en5}, 2'b00);
    check("reset_wr_addr", {wr_addr0, wr_addr5}, 8'h00);
    check("reset_wr_data", wr_data0 | wr_data5, 128'h0);
    check("reset_done",    {done0, done5}, 2'b00);
    check("reset_busy",    {busy0, busy5}, 2'b00);
    check("reset_ready",   {ready0, ready5}, 2'b11);
    @(posedge CLK); #1;
    RST = 1'b0;

    run_request(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, '0, 0);
    check("fips_rk0",  cap[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("fips_rk1",  cap[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_request(128'h0, 1'b0, '0, 0);
    check("zero_rk1",  cap[1],  128'h62636363626363636263636362636363);
    check("zero_rk10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    k1 = rand_key();
    k2 = rand_key();
    run_request(k1, 1'b1, k2, 0);
    run_request(k2, 1'b0, '0, 0);

    run_request(rand_key(), 1'b0, '0, 6);
    run_request(rand_key(), 1'b0, '0, 0);

    for (int n = 0; n < 5; n++) run_request(rand_key(), 1'b0, '0, 0);

    start_valid = 1'b0;
    for (int n = 0; n < 100; n++) begin
      key_in = rand_key();
      @(posedge CLK); #1;
      check("idle_quiet", {wr_en0, done0, busy0, wr_en5, done5, busy5}, 6'b000000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/aes_key_expander.md
# aes_key_expander

AES-128 key-schedule engine that sits directly upstream of the round-key register file. It accepts one 128-bit cipher key through a valid/ready handshake. It then computes the 11 round keys sequentially, one per cycle, and drives them into the register file's single write port (address, data, write enable). The cipher datapath reads the stored keys through the register file's read ports once `done` pulses.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: width of `wr_addr`. `BASE_ADDR + 10` must fit in this width.
- `BASE_ADDR`, default 0: register-file address of round key 0. Round key i goes to `BASE_ADDR + i`.

Clocking and reset: one clock; reset is asynchronous and active-high.

Ports:
- `CLK`  in  1: clock. All flops update on posedge.
- `RST`  in  1: asynchronous, active-high reset.
- `start_valid`  in  1: new key request.
- `start_ready`  out  1: engine idle, request can be accepted.
- `key_in`  in  128: cipher key. `key_in[127:96]` is w0.
- `wr_en`  out  1: register-file write enable (registered).
- `wr_addr`  out  ADDR_WIDTH: register-file write address (registered).
- `wr_data`  out  128: round key (registered). w[4i] occupies `[127:96]`.
- `busy`  out  1: expansion in progress.
- `done`  out  1: one-cycle pulse after the last write.

## Operation
- FSM states: IDLE → EXPAND → DONE → IDLE.
- **IDLE:**
  - `start_ready`=1.
  - On `start_valid && start_ready`: latch `key_in` into the working-key register, set round counter `rnd`=0, go to EXPAND.
- **EXPAND:**
  - Each cycle, register `wr_en`=1, `wr_addr`=`BASE_ADDR+rnd`, `wr_data`=working key.
  - Replace the working key with the next round key using `rcon[rnd]`, then increment `rnd`.
  - After the write with `rnd`=10, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE.
- **Next-key function:**
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RotWord rotates left by one byte. SubWord applies the AES S-box to each byte.
- **rcon sequence** (index 0..9): 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. The 11th computed key is discarded, so no rcon[10] is needed.
- `start_valid` while not in IDLE: ignored. No latch occurs and `key_in` is not sampled.
- `busy` = (state != IDLE). `start_ready` = (state == IDLE).
- `wr_en` is never asserted outside EXPAND writes. Exactly 11 writes per accepted request.
- Address arithmetic: `BASE_ADDR+rnd` is computed in ADDR_WIDTH bits. No wrap is permitted, per the parameter constraint. A simulation assertion checks this.

## Timing
- Accept at cycle 0. Writes occur on cycles 1..11 (round key i on cycle i+1). `done` on cycle 12. `start_ready`=1 again on cycle 13.
- Back-to-back requests: the second key can be accepted on cycle 13. Minimum request period is 13 cycles.
- Reset values:
  - state=IDLE, `rnd`=0, working key=0.
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `busy`=0, `start_ready`=1.
  - Reset takes effect immediately, asynchronously.
- Reset mid-expansion: `wr_en` drops at once and the request is abandoned. Writes already issued remain in the register file. `done` is not pulsed. Next accept requires a fresh handshake.
- The register file has a write-then-read cycle of latency. Consumers must read only after `done`; `done` follows the last write by one cycle, so all keys are visible.

## Structure
- Shared package `aes_pkg`:
  - AES S-box table, exported as a function `sbox(byte)`.
  - rcon constant array.
  - Localparams `NUM_ROUND_KEYS`=11 and `KEY_WIDTH`=128.
  - FSM state enum.
- One combinational sub-module `aes_sub_word`: 32-bit in/out, four S-box lookups. It is reused later by the cipher's SubBytes stage.
- Top module holds the FSM, round counter, working-key register and registered write port.

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `BASE_ADDR`=0:
  - Write on cycle 1 at addr 0 = key.
  - Cycle 2 at addr 1 = `a0fafe1788542cb123a339392a6c7605`.
  - Cycle 11 at addr 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - `done` on cycle 12.
- All-zero key:
  - addr 1 = `62636363626363636263636362636363`.
  - addr 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- `BASE_ADDR`=5, `ADDR_WIDTH`=4: writes hit addresses 5..15 in order. `wr_en` count = 11.
- `start_valid` held high with a different key throughout expansion: all 11 writes match the first key. Second accept occurs on cycle 13 and produces the second key's schedule.
- `RST` asserted on cycle 6:
  - Same cycle, `wr_en`=0, `busy`=0, `start_ready`=1.
  - No `done`.
  - Subsequent request completes with correct values.
- Idle bench: `start_valid`=0 for 100 cycles → `wr_en`, `done`, `busy` remain 0.
